// File: rtl/spr_pkg.sv
// Shared sprite pipeline definitions: default colour depth and the
// transparent index, plus the collision pair-to-bit mapping.
package spr_pkg;

    localparam int COLR_BITS_DEF = 4;
    localparam int TRANSP_DEF    = 0;

    // Bit position of pair (i,j), i<j, in lexicographic pair order.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/spr_pri_sel.sv
// Combinational front-to-back sprite select: the lowest-index opaque
// sprite wins; hit flags that any sprite is opaque.
module spr_pri_sel
    import spr_pkg::*;
#(
    parameter int NUM_SPR   = 4,
    parameter int COLR_BITS = COLR_BITS_DEF,
    parameter int TRANSP    = TRANSP_DEF
) (
    input  logic [NUM_SPR-1:0]           drawing,
    input  logic [NUM_SPR*COLR_BITS-1:0] pix,
    output logic                         hit,
    output logic [COLR_BITS-1:0]         colr
);

    localparam logic [COLR_BITS-1:0] TR = COLR_BITS'(TRANSP);

    // Walk back to front so the frontmost opaque sprite is written last.
    always_comb begin
        hit  = 1'b0;
        colr = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (drawing[i] && pix[i*COLR_BITS +: COLR_BITS] != TR) begin
                hit  = 1'b1;
                colr = pix[i*COLR_BITS +: COLR_BITS];
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite layer compositor with per-frame pairwise collision snapshots.
// Collision logic is built only when SPRITE_COMPOSITOR_COLLISION_EN is defined.
module sprite_compositor
    import spr_pkg::*;
#(
    parameter int NUM_SPR   = 4,
    parameter int COLR_BITS = COLR_BITS_DEF,
    parameter int TRANSP    = TRANSP_DEF,
    localparam int NP       = NUM_SPR * (NUM_SPR - 1) / 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame,
    input  logic                         de,
    input  logic [NUM_SPR-1:0]           spr_drawing,
    input  logic [NUM_SPR*COLR_BITS-1:0] spr_pix,
    input  logic [COLR_BITS-1:0]         bg_colr,
    output logic [COLR_BITS-1:0]         colr,
    output logic                         de_out,
    output logic [NP-1:0]                coll,
    output logic                         coll_valid,
    input  logic                         coll_ack,
    output logic                         coll_ovf
);

    logic                 win_hit;
    logic [COLR_BITS-1:0] win_colr;

    spr_pri_sel #(
        .NUM_SPR   (NUM_SPR),
        .COLR_BITS (COLR_BITS),
        .TRANSP    (TRANSP)
    ) u_pri_sel (
        .drawing (spr_drawing),
        .pix     (spr_pix),
        .hit     (win_hit),
        .colr    (win_colr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            colr   <= '0;
            de_out <= 1'b0;
        end else begin
            de_out <= de;
            if (!de)
                colr <= '0;
            else if (win_hit)
                colr <= win_colr;
            else
                colr <= bg_colr;
        end
    end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    localparam logic [COLR_BITS-1:0] TR = COLR_BITS'(TRANSP);

    logic [NUM_SPR-1:0] opq;
    logic [NP-1:0]      hits;
    logic [NP-1:0]      acc;

    always_comb begin
        opq = '0;
        for (int i = 0; i < NUM_SPR; i++)
            opq[i] = spr_drawing[i] && spr_pix[i*COLR_BITS +: COLR_BITS] != TR;
    end

    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_SPR - 1; i++)
            for (int j = i + 1; j < NUM_SPR; j++)
                hits = hits | (NP'(de & opq[i] & opq[j]) << pair_idx(i, j, NUM_SPR));
    end

    // A frame pulse outranks a same-cycle ack: the new snapshot stays unread.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            coll       <= '0;
            coll_valid <= 1'b0;
            coll_ovf   <= 1'b0;
        end else if (frame) begin
            acc        <= '0;
            coll       <= acc | hits;
            coll_valid <= 1'b1;
            if (coll_valid && !coll_ack)
                coll_ovf <= 1'b1;
        end else begin
            acc <= acc | hits;
            if (coll_valid && coll_ack) begin
                coll_valid <= 1'b0;
                coll_ovf   <= 1'b0;
            end
        end
    end
`else
    logic unused_ack;

    assign unused_ack = coll_ack;
    assign coll       = '0;
    assign coll_valid = 1'b0;
    assign coll_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor (4 sprites, 4-bit colour).
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int CB = 4;
    localparam int NP = NS * (NS - 1) / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame;
    logic          de;
    logic [NS-1:0] spr_drawing;
    logic [15:0]   spr_pix;
    logic [CB-1:0] bg_colr;
    logic [CB-1:0] colr;
    logic          de_out;
    logic [NP-1:0] coll;
    logic          coll_valid;
    logic          coll_ack;
    logic          coll_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    sprite_compositor #(
        .NUM_SPR   (NS),
        .COLR_BITS (CB),
        .TRANSP    (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .de          (de),
        .spr_drawing (spr_drawing),
        .spr_pix     (spr_pix),
        .bg_colr     (bg_colr),
        .colr        (colr),
        .de_out      (de_out),
        .coll        (coll),
        .coll_valid  (coll_valid),
        .coll_ack    (coll_ack),
        .coll_ovf    (coll_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic [3:0] dr, input logic [15:0] px,
                       input logic [3:0] bg, input logic fr, input logic ak);
        de          = d;
        spr_drawing = dr;
        spr_pix     = px;
        bg_colr     = bg;
        frame       = fr;
        coll_ack    = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pix(input string tag, input logic [3:0] ec, input logic ed);
        check({tag, "_colr"}, 32'(colr), 32'(ec));
        check({tag, "_de_out"}, 32'(de_out), 32'(ed));
    endtask

    task automatic chk_coll(input string tag, input logic [5:0] ec,
                            input logic ev, input logic eo);
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
        check({tag, "_coll"}, 32'(coll), 32'(ec));
        check({tag, "_valid"}, 32'(coll_valid), 32'(ev));
        check({tag, "_ovf"}, 32'(coll_ovf), 32'(eo));
`else
        check({tag, "_coll"}, 32'(coll), 32'(6'b0 & ec));
        check({tag, "_valid"}, 32'(coll_valid), 32'(1'b0 & ev));
        check({tag, "_ovf"}, 32'(coll_ovf), 32'(1'b0 & eo));
`endif
    endtask

    initial begin
        rst = 1'b1;
        cyc(1'b1, 4'b0011, 16'h0011, 4'h3, 1'b1, 1'b0);
        cyc(1'b1, 4'b0011, 16'h0011, 4'h3, 1'b0, 1'b0);
        chk_pix("reset", 4'h0, 1'b0);
        chk_coll("reset", 6'b000000, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b0, 1'b0);

        // Transparent front sprite shows background, no collision.
        cyc(1'b1, 4'b0001, 16'h0000, 4'h3, 1'b0, 1'b0);
        chk_pix("transp", 4'h3, 1'b1);
        // Blanking forces colour 0 and records no hit.
        cyc(1'b0, 4'b0110, 16'h0950, 4'h3, 1'b0, 1'b0);
        chk_pix("blank", 4'h0, 1'b0);
        // Sprite 1 beats sprite 2; pair (1,2) = bit 3.
        cyc(1'b1, 4'b0110, 16'h0950, 4'h3, 1'b0, 1'b0);
        chk_pix("pri12", 4'h5, 1'b1);
        // Sprite 2 beats sprite 3; pair (2,3) = bit 5.
        cyc(1'b1, 4'b1100, 16'hAB00, 4'h3, 1'b0, 1'b0);
        chk_pix("pri23", 4'hB, 1'b1);
        // Non-drawing sprites ignored even with non-transparent pix.
        cyc(1'b1, 4'b0000, 16'h1234, 4'hE, 1'b0, 1'b0);
        chk_pix("nodraw", 4'hE, 1'b1);
        chk_coll("midframe", 6'b000000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b1, 1'b0);
        chk_coll("frame1", 6'b101000, 1'b1, 1'b0);

        // Pair (1,3) = bit 4; second unacked frame overflows.
        cyc(1'b1, 4'b1010, 16'h6020, 4'h3, 1'b0, 1'b0);
        chk_pix("pri13", 4'h2, 1'b1);
        chk_coll("hold", 6'b101000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b1, 1'b0);
        chk_coll("frame2", 6'b010000, 1'b1, 1'b1);
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b0, 1'b1);
        chk_coll("ack", 6'b010000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b0, 1'b1);
        chk_coll("ack_idle", 6'b010000, 1'b0, 1'b0);

        // Frame and ack together: frame wins, same-cycle hit included.
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b1, 1'b0);
        chk_coll("frame3", 6'b000000, 1'b1, 1'b0);
        cyc(1'b1, 4'b0011, 16'h0011, 4'h3, 1'b0, 1'b0);
        chk_pix("pri01", 4'h1, 1'b1);
        chk_coll("stable", 6'b000000, 1'b1, 1'b0);
        cyc(1'b1, 4'b0101, 16'h0101, 4'h3, 1'b1, 1'b1);
        chk_pix("pri02", 4'h1, 1'b1);
        chk_coll("frame_ack", 6'b000011, 1'b1, 1'b0);

        // Mid-frame reset discards the accumulated hit.
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b0, 1'b1);
        chk_coll("ack2", 6'b000011, 1'b0, 1'b0);
        cyc(1'b1, 4'b0011, 16'h0011, 4'h3, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 4'b0000, 16'h0000, 4'h3, 1'b1, 1'b1);
        chk_pix("rst_mid", 4'h0, 1'b0);
        chk_coll("rst_mid", 6'b000000, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b1, 1'b0);
        chk_coll("frame_rst", 6'b000000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 16'h0000, 4'h3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
